output_deskewer: RTL and testbench
==================================

OUTPUT_DESKEWER -- requirements
Module: output_deskewer

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 2: array dimension N; number of result columns and of rows per frame.
REQ-002 SHALL have parameter DATA_SIZE, default 32: width of each result element in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: global advance; low stalls all internal state.
REQ-006 SHALL have port in_valid, input, 1 bit: column 0 of in_sum carries a valid row this cycle.
REQ-007 SHALL have port in_sum, input, N x DATA_SIZE unpacked array: skewed array outputs; column j of a row arrives j cycles after column 0.
REQ-008 SHALL have port result_out, output, N x DATA_SIZE unpacked array: realigned row, all columns from the same row.
REQ-009 SHALL have port out_valid, output, 1 bit: result_out holds a complete aligned row.
REQ-010 SHALL have port finished, output, 1 bit: all N rows of the current frame have been output.
REQ-011 SHALL have port overflow, output, 1 bit: sticky; more than N rows were accepted in one frame.

Function
REQ-012 SHALL delay column j through exactly N-j registers, the last being the result_out register, so that every column of a row is presented in the same cycle.
REQ-013 SHALL delay in_valid through an N-stage register chain whose output is out_valid.
REQ-014 SHALL make latency exactly N enabled cycles: in_valid sampled at enabled edge k -> out_valid and result_out for that row valid after enabled edge k+N.
REQ-015 SHALL sample in_sum column j for a row at enabled edge k+j, where k is that row's in_valid edge; the caller guarantees this column timing.
REQ-016 SHALL pass data bit-exact, with no arithmetic, truncation or sign handling.
REQ-017 SHALL accept in_valid on consecutive cycles (one row per cycle) and with arbitrary gaps between rows.
REQ-018 SHALL, while enable is low, hold every delay register, the valid chain, the counters, the FSM and all outputs unchanged, and ignore in_valid and in_sum.
REQ-019 SHALL implement an FSM with states IDLE, COLLECT and DONE.
REQ-020 SHALL transition IDLE -> COLLECT on the first enabled in_valid; rows_in = 1 and rows_out = 0 at that point.
REQ-021 SHALL, in COLLECT, increment rows_in on each enabled in_valid and rows_out on each enabled out_valid; both counters are sized to hold 0..N.
REQ-022 SHALL transition COLLECT -> DONE on the edge where rows_out reaches N; finished goes high on that same edge and stays high while in DONE.
REQ-023 SHALL, in DONE, on an enabled in_valid: start a new frame, move to COLLECT, set rows_in = 1 and rows_out = 0, and deassert finished on that edge.
REQ-024 SHALL, on an in_valid accepted in COLLECT with rows_in already N: set overflow and still shift the row through the datapath; rows_in saturates at N.
REQ-025 SHALL count an out_valid of the old frame toward the old frame when it coincides with the first in_valid of a new frame; the new frame's rows_out starts at 0 on the following edge.
REQ-026 SHALL give out_valid priority over the DONE transition only by counting it: the DONE transition occurs when the N-th out_valid is counted.
REQ-027 SHALL clear overflow only by reset.

Reset
REQ-028 SHALL, while reset is low, immediately force: FSM = IDLE, counters = 0, valid chain = 0, out_valid = 0, finished = 0, overflow = 0, and every result_out element = 0.
REQ-029 SHALL, on reset asserted mid-frame, discard all in-flight rows; no out_valid appears for them after release.
REQ-030 SHALL resume normal operation on the first rising clk edge after reset rises.

Verification
REQ-031 SHALL pass this test: N=2, enable=1, in_valid at edge 0 with col0=5, col1=7 at edge 1 -> after edge 2 result_out={5,7}, out_valid=1.
REQ-032 SHALL pass this test: N=2, back-to-back rows {1,2} then {3,4} -> out_valid high for 2 cycles with {1,2} then {3,4}; finished high after the second row's edge.
REQ-033 SHALL pass this test: enable low for 3 cycles mid-pipeline -> outputs frozen; rows emerge 3 cycles later with unchanged values.
REQ-034 SHALL pass this test: N=2, a third in_valid before DONE -> overflow=1 and stays 1 until reset.
REQ-035 SHALL pass this test: reset low while one row is in flight -> all outputs 0 immediately; no out_valid after release.
REQ-036 SHALL pass this test: from DONE, new in_valid -> finished=0 on that edge; the new frame completes with finished=1 after N further rows.

Source files
------------

// File: rtl/output_deskewer.sv
// ============================================================================
// output_deskewer: realigns skewed systolic-array result columns into whole rows
// and tracks per-frame row completion, raising finished and a sticky overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module output_deskewer #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_sum     [MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] result_out [MATRIX_SIZE],
    output logic                 out_valid,
    output logic                 finished,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(MATRIX_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     rows_in;
    logic [CNT_W-1:0]     rows_out;
    logic [MATRIX_SIZE-1:0] valid_chain;

    // Column j arrives j cycles late, so it needs j fewer stages; the last
    // stage of every column is the result_out register itself.
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
        localparam int DEPTH = MATRIX_SIZE - j;
        logic [DATA_SIZE-1:0] pipe [DEPTH];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            end else if (enable) begin
                pipe[0] <= in_sum[j];
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign result_out[j] = pipe[DEPTH-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_chain <= '0;
        end else if (enable) begin
            valid_chain[0] <= in_valid;
            for (int i = 1; i < MATRIX_SIZE; i++) valid_chain[i] <= valid_chain[i-1];
        end
    end

    assign out_valid = valid_chain[MATRIX_SIZE-1];

    // Out_valid seen in DONE belongs to an overflowed row of the finished
    // frame and is deliberately not counted toward the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rows_in  <= '0;
            rows_out <= '0;
            finished <= 1'b0;
            overflow <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= COLLECT;
                        rows_in  <= CNT_ONE;
                        rows_out <= '0;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (rows_in == N_CNT) overflow <= 1'b1;
                        else                  rows_in  <= rows_in + CNT_ONE;
                    end
                    if (out_valid) begin
                        rows_out <= rows_out + CNT_ONE;
                        if (rows_out == N_CNT - CNT_ONE) begin
                            state    <= DONE;
                            finished <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        state    <= COLLECT;
                        rows_in  <= CNT_ONE;
                        rows_out <= '0;
                        finished <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_output_deskewer.sv
// ============================================================================
// tb_output_deskewer: directed and randomized checks of output_deskewer against
// a row/frame-level reference model. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_output_deskewer;

    localparam int N  = 2;
    localparam int DS = 32;
    typedef logic [DS-1:0] row_t [N];

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [DS-1:0] in_sum     [N];
    logic [DS-1:0] result_out [N];
    logic          out_valid, finished, overflow;

    always #5 clk = ~clk;

    output_deskewer #(.MATRIX_SIZE(N), .DATA_SIZE(DS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_sum(in_sum), .result_out(result_out), .out_valid(out_valid),
        .finished(finished), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: rows indexed by enabled cycle; a row issued in enabled
    // cycle t is visible in enabled cycle t+N. Frame bookkeeping by counting.
    row_t rhist [4096];
    bit   vhist [4096];
    int   ecyc = 0;
    int   base = 0;
    bit   exp_ov, exp_fin, exp_ovf, collecting;
    int   nin, nout;
    row_t exp_row;
    row_t zero_row;

    function automatic bit hist_valid(input int i);
        return (i >= base) && vhist[i];
    endfunction

    function automatic row_t mk2(input logic [DS-1:0] a, input logic [DS-1:0] b);
        row_t r;
        r[0] = a;
        r[1] = b;
        return r;
    endfunction

    // Drive one cycle (column j carries the row issued j enabled cycles ago),
    // let the edge pass, and advance the model to the new visible interval.
    task automatic step(input bit en, input bit v, input row_t r);
        bit was_col, outv;
        enable = en;
        if (en) begin
            vhist[ecyc] = v;
            rhist[ecyc] = r;
            in_valid = v;
            for (int j = 0; j < N; j++)
                in_sum[j] = hist_valid(ecyc - j) ? rhist[ecyc-j][j] : $urandom;
        end else begin
            in_valid = 1'($urandom);
            for (int j = 0; j < N; j++) in_sum[j] = $urandom;
        end
        @(posedge clk);
        #1;
        if (en) begin
            was_col = collecting;
            outv    = exp_ov;
            if (was_col && outv) begin
                nout++;
                if (nout == N) begin
                    collecting = 1'b0;
                    exp_fin    = 1'b1;
                end
            end
            if (v) begin
                if (!was_col) begin
                    collecting = 1'b1;
                    nin = 1;
                    nout = 0;
                    exp_fin = 1'b0;
                end else if (nin == N) begin
                    exp_ovf = 1'b1;
                end else begin
                    nin++;
                end
            end
            ecyc++;
            exp_ov = hist_valid(ecyc - N);
            if (exp_ov) exp_row = rhist[ecyc-N];
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        in_valid = 1'b0;
        #1;
        base = ecyc;
        collecting = 1'b0;
        exp_ov = 1'b0;
        exp_fin = 1'b0;
        exp_ovf = 1'b0;
        nin = 0;
        nout = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (finished  !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b exp=0", finished); end
        checks++; if (overflow  !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (result_out[j] !== '0) begin errors++; $display("FAIL reset_result col=%0d got=%h exp=0", j, result_out[j]); end
        end
        release_reset();
    endtask

    task automatic test_single();
        int seen_at = -1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 1'b1, mk2(32'd5, 32'd7));
            else        step(1'b1, 1'b0, zero_row);
            if (out_valid === 1'b1 && seen_at < 0) seen_at = i + 1;
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL single_out_valid step=%0d got=%b exp=%b", i, out_valid, exp_ov); end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL single_result step=%0d col=%0d got=%0d exp=%0d", i, j, result_out[j], exp_row[j]); end
            end
        end
        checks++;
        if (seen_at != N) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", seen_at, N); end
    endtask

    task automatic test_back_to_back();
        assert_reset();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      step(1'b1, 1'b1, mk2(32'd1, 32'd2));
            else if (i == 1) step(1'b1, 1'b1, mk2(32'd3, 32'd4));
            else             step(1'b1, 1'b0, zero_row);
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL b2b_out_valid step=%0d got=%b exp=%b", i, out_valid, exp_ov); end
            checks++;
            if (finished !== exp_fin) begin errors++; $display("FAIL b2b_finished step=%0d got=%b exp=%b", i, finished, exp_fin); end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL b2b_result step=%0d col=%0d got=%0d exp=%0d", i, j, result_out[j], exp_row[j]); end
            end
        end
    endtask

    task automatic test_stall();
        bit en_tab [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        assert_reset();
        release_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 2) step(en_tab[i], 1'b1, mk2($urandom, $urandom));
            else       step(en_tab[i], 1'b0, zero_row);
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL stall_out_valid step=%0d got=%b exp=%b", i, out_valid, exp_ov); end
            checks++;
            if (finished !== exp_fin) begin errors++; $display("FAIL stall_finished step=%0d got=%b exp=%b", i, finished, exp_fin); end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL stall_result step=%0d col=%0d got=%h exp=%h", i, j, result_out[j], exp_row[j]); end
            end
        end
    endtask

    task automatic test_new_frame();
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL newframe_done got=%b exp=1", finished); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 2), mk2($urandom, $urandom));
            checks++;
            if (finished !== exp_fin) begin errors++; $display("FAIL newframe_finished step=%0d got=%b exp=%b", i, finished, exp_fin); end
            if (i == 0) begin
                checks++;
                if (finished !== 1'b0) begin errors++; $display("FAIL newframe_clear got=%b exp=0", finished); end
            end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL newframe_result step=%0d col=%0d got=%h exp=%h", i, j, result_out[j], exp_row[j]); end
            end
        end
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL newframe_end got=%b exp=1", finished); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i < 3) || (i == 7), mk2($urandom, $urandom));
            checks++;
            if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag step=%0d got=%b exp=%b", i, overflow, exp_ovf); end
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL ovf_out_valid step=%0d got=%b exp=%b", i, out_valid, exp_ov); end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL ovf_result step=%0d col=%0d got=%h exp=%h", i, j, result_out[j], exp_row[j]); end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b1, mk2($urandom, $urandom));
        step(1'b1, 1'b0, zero_row);
        assert_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (overflow  !== 1'b0) begin errors++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
        checks++; if (finished  !== 1'b0) begin errors++; $display("FAIL midrst_finished got=%b exp=0", finished); end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (result_out[j] !== '0) begin errors++; $display("FAIL midrst_result col=%0d got=%h exp=0", j, result_out[j]); end
        end
        release_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, zero_row);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost step=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), mk2($urandom, $urandom));
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid step=%0d got=%b exp=%b", i, out_valid, exp_ov); end
            checks++;
            if (finished !== exp_fin) begin errors++; $display("FAIL rnd_finished step=%0d got=%b exp=%b", i, finished, exp_fin); end
            checks++;
            if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd_overflow step=%0d got=%b exp=%b", i, overflow, exp_ovf); end
            if (exp_ov) for (int j = 0; j < N; j++) begin
                checks++;
                if (result_out[j] !== exp_row[j]) begin errors++; $display("FAIL rnd_result step=%0d col=%0d got=%h exp=%h", i, j, result_out[j], exp_row[j]); end
            end
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            in_sum[j]   = '0;
            zero_row[j] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_new_frame();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
